// File: rtl/palette_arbiter_if.sv
// Bus bundle between the palette arbiter, its two read requesters and the shared colour ROM.
interface palette_arbiter_if;
    logic        req_a;
    logic [3:0]  addr_a;
    logic        req_b;
    logic [3:0]  addr_b;
    logic        gnt_a;
    logic        gnt_b;
    logic        valid_a;
    logic        valid_b;
    logic [23:0] data_out;
    logic [3:0]  rom_address;
    logic [23:0] rom_q;

    modport master (
        output req_a, addr_a, req_b, addr_b, rom_q,
        input  gnt_a, gnt_b, valid_a, valid_b, data_out, rom_address
    );

    modport slave (
        input  req_a, addr_a, req_b, addr_b, rom_q,
        output gnt_a, gnt_b, valid_a, valid_b, data_out, rom_address
    );
endinterface

// File: rtl/palette_arbiter.sv
// Two-port arbiter in front of a registered 16x24 palette ROM: port A has priority,
// port B is forced through after STARVE_LIMIT consecutive denied cycles.
module palette_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input logic             clk,
    input logic             reset,
    palette_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_next;
    logic       force_b;
    logic       gnt_a;
    logic       gnt_b;
    logic       valid_a_q;
    logic       valid_b_q;

    always_comb begin
        force_b = bus.req_b && (starve_cnt == LIMIT);
    end

    // Grants are decided combinationally so the ROM sees the address in the request cycle.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset) begin
            if (force_b) begin
                gnt_b = 1'b1;
            end else if (bus.req_a) begin
                gnt_a = 1'b1;
            end else if (bus.req_b) begin
                gnt_b = 1'b1;
            end
        end
    end

    always_comb begin
        bus.rom_address = 4'h0;
        if (gnt_a) begin
            bus.rom_address = bus.addr_a;
        end else if (gnt_b) begin
            bus.rom_address = bus.addr_b;
        end
    end

    always_comb begin
        starve_cnt_next = 4'h0;
        if (bus.req_b && !gnt_b) begin
            if (starve_cnt >= LIMIT) begin
                starve_cnt_next = LIMIT;
            end else begin
                starve_cnt_next = starve_cnt + 4'h1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 4'h0;
            valid_a_q  <= 1'b0;
            valid_b_q  <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_next;
            valid_a_q  <= gnt_a;
            valid_b_q  <= gnt_b;
        end
    end

    // Masking with reset discards a read whose data would land in a reset cycle.
    always_comb begin
        bus.gnt_a    = gnt_a;
        bus.gnt_b    = gnt_b;
        bus.valid_a  = valid_a_q && !reset;
        bus.valid_b  = valid_b_q && !reset;
        bus.data_out = bus.rom_q;
    end

endmodule

// File: tb/tb_palette_arbiter.sv
// Randomised scoreboard bench for palette_arbiter with a registered ROM model.
module tb_palette_arbiter;

    localparam int STARVE_LIMIT = 3;

    typedef struct {
        int          due;
        bit          is_b;
        logic [23:0] data;
    } expect_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   checking = 1'b0;
    int   starve = 0;
    bit   exp_a;
    bit   exp_b;
    expect_t sb_q[$];
    expect_t mon_e;

    palette_arbiter_if bus ();

    palette_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM: entry k is the nibble k replicated six times, one cycle after address capture.
    always @(posedge clk) bus.rom_q <= {6{bus.rom_address}};

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
        end
    endtask

    // Drives one cycle of requests, predicts the grant from the arbitration rules and
    // queues the read response expected on the following cycle.
    task automatic apply_stimulus(input bit r, input bit ra, input logic [3:0] aa,
                                  input bit rb, input logic [3:0] ab);
        logic [3:0] exp_addr;
        @(posedge clk);
        #1;
        reset      = r;
        bus.req_a  = ra;
        bus.addr_a = aa;
        bus.req_b  = rb;
        bus.addr_b = ab;
        exp_a = 1'b0;
        exp_b = 1'b0;
        if (r) begin
            while (sb_q.size() > 0 && sb_q[sb_q.size()-1].due == cyc) void'(sb_q.pop_back());
        end else if (rb && starve >= STARVE_LIMIT) begin
            exp_b = 1'b1;
        end else if (ra) begin
            exp_a = 1'b1;
        end else if (rb) begin
            exp_b = 1'b1;
        end
        if (r || !rb || exp_b) starve = 0;
        else if (starve < STARVE_LIMIT) starve = starve + 1;
        exp_addr = exp_a ? aa : (exp_b ? ab : 4'h0);
        if (exp_a || exp_b) sb_q.push_back('{due: cyc + 1, is_b: exp_b, data: {6{exp_addr}}});
        @(negedge clk);
        check_output("gnt_a", {31'b0, bus.gnt_a}, {31'b0, exp_a});
        check_output("gnt_b", {31'b0, bus.gnt_b}, {31'b0, exp_b});
        check_output("rom_address", {28'b0, bus.rom_address}, {28'b0, exp_addr});
    endtask

    // Monitor: every cycle either the queued response or silence must appear.
    always @(negedge clk) begin
        if (checking) begin
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                mon_e = sb_q.pop_front();
                check_output("valid_a", {31'b0, bus.valid_a}, {31'b0, !mon_e.is_b});
                check_output("valid_b", {31'b0, bus.valid_b}, {31'b0, mon_e.is_b});
                check_output("data_out", {8'b0, bus.data_out}, {8'b0, mon_e.data});
            end else begin
                check_output("idle_valid", {30'b0, bus.valid_a, bus.valid_b}, 32'h0);
            end
        end
    end

    initial begin
        bit         pend_a = 1'b0;
        bit         pend_b = 1'b0;
        bit         rr, ra, rb;
        logic [3:0] aa = 4'h0;
        logic [3:0] ab = 4'h0;

        bus.req_a  = 1'b0;
        bus.addr_a = 4'h0;
        bus.req_b  = 1'b0;
        bus.addr_b = 4'h0;
        repeat (3) apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        checking = 1'b1;

        // Grant in the first cycle out of reset, both ports on the same address.
        apply_stimulus(1'b0, 1'b1, 4'h7, 1'b1, 4'h7);
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'h7);
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);

        apply_stimulus(1'b0, 1'b1, 4'h5, 1'b0, 4'h0);
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);

        repeat (8) apply_stimulus(1'b0, 1'b1, 4'h2, 1'b1, 4'h9);
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);

        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'h1);
        apply_stimulus(1'b0, 1'b1, 4'hF, 1'b0, 4'h0);
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);

        apply_stimulus(1'b0, 1'b1, 4'h6, 1'b1, 4'h3);
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'h3);
        apply_stimulus(1'b1, 1'b1, 4'h4, 1'b1, 4'h4);
        apply_stimulus(1'b1, 1'b1, 4'h4, 1'b1, 4'h4);
        repeat (5) apply_stimulus(1'b0, 1'b1, 4'hA, 1'b1, 4'hC);

        repeat (10) apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);

        repeat (2) apply_stimulus(1'b0, 1'b1, 4'h3, 1'b1, 4'h8);
        apply_stimulus(1'b0, 1'b1, 4'h3, 1'b0, 4'h0);
        repeat (5) apply_stimulus(1'b0, 1'b1, 4'hB, 1'b1, 4'hD);

        // Random traffic: denied requesters usually hold their request, occasionally drop it.
        repeat (3000) begin
            rr = ($urandom_range(0, 99) < 2);
            if (!(pend_a && $urandom_range(0, 9) != 0)) begin
                ra = ($urandom_range(0, 99) < 60);
                aa = 4'($urandom_range(0, 15));
            end
            if (!(pend_b && $urandom_range(0, 9) != 0)) begin
                rb = ($urandom_range(0, 99) < 50);
                ab = 4'($urandom_range(0, 15));
            end
            apply_stimulus(rr, ra, aa, rb, ab);
            pend_a = ra && !exp_a;
            pend_b = rb && !exp_b;
        end

        repeat (3) apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        check_output("scoreboard_drained", sb_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/palette_arbiter.md
PALETTE_ARBITER -- requirements
Module: palette_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 3, setting how many consecutive denied cycles port B may see before it is forced a grant (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req_a, input, 1 bit: read request from the renderer, the priority port.
REQ-005 The block SHALL have port addr_a, input, 4 bits: palette index requested by port A.
REQ-006 The block SHALL have port req_b, input, 1 bit: read request from the UI/color-select port.
REQ-007 The block SHALL have port addr_b, input, 4 bits: palette index requested by port B.
REQ-008 The block SHALL have port gnt_a, output, 1 bit: port A request accepted this cycle.
REQ-009 The block SHALL have port gnt_b, output, 1 bit: port B request accepted this cycle.
REQ-010 The block SHALL have port valid_a, output, 1 bit: data_out holds port A's palette entry this cycle.
REQ-011 The block SHALL have port valid_b, output, 1 bit: data_out holds port B's palette entry this cycle.
REQ-012 The block SHALL have port data_out, output, 24 bits: RGB palette entry returned from the ROM.
REQ-013 The block SHALL have port rom_address, output, 4 bits: address to the shared 16x24 color ROM, which registers its address on clk.
REQ-014 The block SHALL have port rom_q, input, 24 bits: ROM data, valid one cycle after its address is sampled.

Function
REQ-015 gnt_a and gnt_b SHALL be combinational from the current requests and state, and SHALL be mutually exclusive.
REQ-016 At most one grant SHALL be issued per cycle; a grant is issued in every cycle in which req_a or req_b is high and reset is low.
REQ-017 rom_address SHALL be addr_a when gnt_a is high, addr_b when gnt_b is high, and 4'h0 when neither is granted.
REQ-018 Default priority: req_a high SHALL give gnt_a, unless the starvation override in REQ-020 is active.
REQ-019 A registered starvation counter (4 bits) SHALL:
- increment by 1 in each cycle where req_b=1 and gnt_b=0;
- clear to 0 in any cycle where gnt_b=1 or req_b=0;
- saturate at STARVE_LIMIT.
REQ-020 When the counter equals STARVE_LIMIT and req_b=1, gnt_b SHALL be issued even if req_a=1, and gnt_a SHALL be 0 that cycle.
REQ-021 A denied requester SHALL keep its req and addr stable until granted; the block SHALL NOT queue requests, and a request dropped before its grant is lost with no response.
REQ-022 Read latency SHALL be exactly 1 cycle: a grant in cycle N produces valid_x=1 in cycle N+1, with data_out = ROM entry at the granted address.
REQ-023 valid_a and valid_b SHALL be registered copies of gnt_a and gnt_b, and SHALL be mutually exclusive.
REQ-024 data_out SHALL equal rom_q in every cycle; data_out is meaningful only while valid_a or valid_b is high.
REQ-025 Back-to-back grants, on the same or alternating ports, SHALL sustain one read per cycle with no bubble.
REQ-026 Both requests high at the same address SHALL still be serviced as two separate reads on two separate grants.

Reset
REQ-027 While reset=1, the block SHALL force gnt_a=0, gnt_b=0 and rom_address=4'h0, regardless of requests.
REQ-028 On the first rising edge with reset=1, the block SHALL set valid_a=0, valid_b=0 and the starvation counter to 0.
REQ-029 If reset is asserted in the cycle after a grant, that read's valid SHALL be suppressed (valid=0) and the read discarded.
REQ-030 The first grant after reset deassertion SHALL be possible in the first cycle with reset=0.

Verification
ROM model: registered address; entry k = {k, k, k} replicated per nibble (e.g. 5 -> 24'h555555).
REQ-031 A-only read: req_a=1, addr_a=5 for one cycle -> gnt_a=1 and rom_address=5 that cycle; next cycle valid_a=1, valid_b=0, data_out=24'h555555.
REQ-032 Contention: req_a=1 (addr 2) continuously, req_b=1 (addr 9) continuously, STARVE_LIMIT=3 -> gnt_a in cycles 0-2, gnt_b in cycle 3, gnt_a in cycles 4-6, gnt_b in cycle 7; the cycle-4 valid_b carries 24'h999999.
REQ-033 Alternating back-to-back: B alone in cycle 0 (addr 1), then A alone in cycle 1 (addr 15) -> valid_b with 24'h111111 in cycle 1, valid_a with 24'hFFFFFF in cycle 2, no idle cycle between.
REQ-034 Reset mid-read: gnt_b in cycle 0, reset=1 in cycle 1 -> valid_b=0 in cycles 1-2, gnt_a=gnt_b=0 during reset, counter=0 afterward.
REQ-035 Idle: req_a=req_b=0 for 10 cycles -> no grants, no valids, rom_address=0 throughout, counter stays 0.
REQ-036 B request withdrawn: req_b high for 2 denied cycles and then low -> counter returns to 0 and no valid_b is ever produced.
